// File: rtl/seg7_scan_to_bcd_encoder.sv
// rtl/seg7_scan_to_bcd_encoder.sv - 7-seg scan bus to 4-bit code frame encoder
// Optional sticky overrun flag port enabled by defining SEG7_OVERRUN_FLAG_EN.
module seg7_scan_to_bcd_encoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3,
  parameter bit SEG_ACT_LOW   = 1'b0
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel_in,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   invalid_out,
  output logic                    frame_valid_out,
  input  logic                    frame_ready_in
`ifdef SEG7_OVERRUN_FLAG_EN
  ,
  output logic                    overrun_out
`endif
);

  typedef enum logic {COLLECT, PRESENT} state_t;

  localparam logic [3:0]            STB = 4'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

  state_t                  state, state_n;
  logic [6:0]              seg_r, seg_p;
  logic [NUM_DIGITS-1:0]   dig_r, dig_p;
  logic [3:0]              cnt, cnt_n;
  logic                    sel_onehot, same, capture;
  logic [4:0]              dec;
  logic [NUM_DIGITS-1:0]   mask, mask_n;
  logic                    mask_full;
  logic [4*NUM_DIGITS-1:0] shadow_bcd, bcd_n;
  logic [NUM_DIGITS-1:0]   shadow_inv, inv_n;
  logic                    valid_n;

  // Returns {invalid, code}; unknown patterns map to code 0 with invalid set.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F:   decode = 5'h00;
      7'h06:   decode = 5'h01;
      7'h5B:   decode = 5'h02;
      7'h4F:   decode = 5'h03;
      7'h66:   decode = 5'h04;
      7'h6D:   decode = 5'h05;
      7'h7C:   decode = 5'h06;
      7'h07:   decode = 5'h07;
      7'h7F:   decode = 5'h08;
      7'h67:   decode = 5'h09;
      7'h58:   decode = 5'h0A;
      7'h4C:   decode = 5'h0B;
      7'h62:   decode = 5'h0C;
      7'h69:   decode = 5'h0D;
      7'h78:   decode = 5'h0E;
      7'h00:   decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    sel_onehot = (dig_r != '0) && ((dig_r & (dig_r - ONE)) == '0);
    same       = (seg_r == seg_p) && (dig_r == dig_p);
    dec        = decode(seg_r);
    cnt_n      = cnt;
    if (!sel_onehot)
      cnt_n = 4'd0;
    else if (!same)
      cnt_n = 4'd1;
    else if (cnt != STB)
      cnt_n = cnt + 4'd1;
    // Fire only on the transition into the threshold so a held digit is written once.
    capture = sel_onehot && (cnt_n == STB) && ((cnt != STB) || !same);
  end

  assign mask_full = &mask;

  always_comb begin
    state_n = state;
    bcd_n   = bcd_out;
    inv_n   = invalid_out;
    valid_n = frame_valid_out;
    case (state)
      COLLECT: begin
        if (mask_full) begin
          bcd_n   = shadow_bcd;
          inv_n   = shadow_inv;
          valid_n = 1'b1;
          state_n = PRESENT;
        end
      end
      PRESENT: begin
        if (frame_ready_in) begin
          if (mask_full) begin
            bcd_n = shadow_bcd;
            inv_n = shadow_inv;
          end else begin
            valid_n = 1'b0;
            state_n = COLLECT;
          end
        end
      end
      default: state_n = COLLECT;
    endcase
    // A completed mask is always consumed: loaded, reloaded or dropped.
    mask_n = (mask_full ? '0 : mask) | (capture ? dig_r : '0);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state           <= COLLECT;
      seg_r           <= '0;
      seg_p           <= '0;
      dig_r           <= '0;
      dig_p           <= '0;
      cnt             <= '0;
      mask            <= '0;
      shadow_bcd      <= '0;
      shadow_inv      <= '0;
      bcd_out         <= '0;
      invalid_out     <= '0;
      frame_valid_out <= 1'b0;
    end else begin
      state           <= state_n;
      seg_r           <= SEG_ACT_LOW ? ~seg_in : seg_in;
      dig_r           <= dig_sel_in;
      seg_p           <= seg_r;
      dig_p           <= dig_r;
      cnt             <= cnt_n;
      mask            <= mask_n;
      bcd_out         <= bcd_n;
      invalid_out     <= inv_n;
      frame_valid_out <= valid_n;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (capture && dig_r[k]) begin
          shadow_bcd[4*k +: 4] <= dec[3:0];
          shadow_inv[k]        <= dec[4];
        end
      end
    end
  end

`ifdef SEG7_OVERRUN_FLAG_EN
  always_ff @(posedge clk_in) begin
    if (!rst_n_in)
      overrun_out <= 1'b0;
    else if ((state == PRESENT) && !frame_ready_in && mask_full)
      overrun_out <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_seg7_scan_to_bcd_encoder.sv
// tb/tb_seg7_scan_to_bcd_encoder.sv - directed self-checking bench for seg7_scan_to_bcd_encoder
module tb_seg7_scan_to_bcd_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = '0;
  logic [3:0]  dig = '0;
  logic [15:0] bcd;
  logic [3:0]  inv;
  logic        valid;
  logic        ready = 1'b1;
`ifdef SEG7_OVERRUN_FLAG_EN
  logic        overrun;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  seg7_scan_to_bcd_encoder #(
    .NUM_DIGITS(4),
    .STABLE_CYCLES(3),
    .SEG_ACT_LOW(1'b0)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .seg_in(seg),
    .dig_sel_in(dig),
    .bcd_out(bcd),
    .invalid_out(inv),
    .frame_valid_out(valid),
    .frame_ready_in(ready)
`ifdef SEG7_OVERRUN_FLAG_EN
    ,
    .overrun_out(overrun)
`endif
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic show(input logic [3:0] d, input logic [6:0] s, input int n);
    dig = d;
    seg = s;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    dig = '0;
    seg = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 8; i++) begin
      if (valid) break;
      tick();
    end
    total_cnt++;
    if (valid !== 1'b1) $display("FAIL %s_valid_timeout: got %b want 1", name, valid);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dig = 4'b0001;
    seg = 7'h7F;
    tick();
    tick();
    total_cnt++;
    if (bcd !== 16'h0000) $display("FAIL reset_bcd: got %h want 0000", bcd); else pass_cnt++;
    total_cnt++;
    if (inv !== 4'h0) $display("FAIL reset_inv: got %b want 0000", inv); else pass_cnt++;
    total_cnt++;
    if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else pass_cnt++;
`ifdef SEG7_OVERRUN_FLAG_EN
    total_cnt++;
    if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else pass_cnt++;
`endif
    dig = '0;
    seg = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    ready = 1'b1;
    show(4'b0001, 7'h3F, 4);
    show(4'b0010, 7'h06, 4);
    show(4'b0100, 7'h5B, 4);
    show(4'b1000, 7'h4F, 4);
    total_cnt++;
    if (valid !== 1'b0) $display("FAIL basic_valid_early: got %b want 0", valid); else pass_cnt++;
    show(4'b0000, 7'h00, 1);
    total_cnt++;
    if (valid !== 1'b1) $display("FAIL basic_valid_latency: got %b want 1", valid); else pass_cnt++;
    total_cnt++;
    if (bcd !== 16'h3210) $display("FAIL basic_bcd: got %h want 3210", bcd); else pass_cnt++;
    total_cnt++;
    if (inv !== 4'b0000) $display("FAIL basic_inv: got %b want 0000", inv); else pass_cnt++;
    tick();
    total_cnt++;
    if (valid !== 1'b0) $display("FAIL basic_valid_drop: got %b want 0", valid); else pass_cnt++;
  endtask

  task automatic test_glitch();
    ready = 1'b1;
    show(4'b0001, 7'h3F, 4);
    show(4'b0010, 7'h06, 2);
    show(4'b0010, 7'h7F, 3);
    show(4'b0011, 7'h66, 6);
    show(4'b0100, 7'h5B, 4);
    total_cnt++;
    if (valid !== 1'b0) $display("FAIL glitch_no_early_frame: got %b want 0", valid); else pass_cnt++;
    show(4'b1000, 7'h4F, 4);
    dig = '0;
    wait_valid("glitch");
    total_cnt++;
    if (bcd !== 16'h3280) $display("FAIL glitch_bcd: got %h want 3280", bcd); else pass_cnt++;
    tick();
  endtask

  task automatic test_invalid();
    ready = 1'b1;
    show(4'b0001, 7'h00, 4);
    show(4'b0010, 7'h06, 4);
    show(4'b0100, 7'h7D, 3);
    show(4'b1000, 7'h4F, 4);
    dig = '0;
    wait_valid("invalid");
    total_cnt++;
    if (bcd !== 16'h301F) $display("FAIL invalid_bcd: got %h want 301f", bcd); else pass_cnt++;
    total_cnt++;
    if (inv !== 4'b0100) $display("FAIL invalid_flags: got %b want 0100", inv); else pass_cnt++;
    tick();
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    show(4'b0001, 7'h3F, 4);
    show(4'b0010, 7'h06, 4);
    show(4'b0100, 7'h5B, 4);
    show(4'b1000, 7'h4F, 4);
    dig = '0;
    wait_valid("bp_first");
    total_cnt++;
    if (bcd !== 16'h3210) $display("FAIL bp_first_bcd: got %h want 3210", bcd); else pass_cnt++;
    show(4'b0001, 7'h7F, 4);
    show(4'b0010, 7'h67, 4);
    total_cnt++;
    if (bcd !== 16'h3210) $display("FAIL bp_mid_hold: got %h want 3210", bcd); else pass_cnt++;
    show(4'b0100, 7'h58, 4);
    show(4'b1000, 7'h4C, 4);
    show(4'b0000, 7'h00, 3);
    total_cnt++;
    if (valid !== 1'b1) $display("FAIL bp_valid_held: got %b want 1", valid); else pass_cnt++;
    total_cnt++;
    if (bcd !== 16'h3210) $display("FAIL bp_second_dropped: got %h want 3210", bcd); else pass_cnt++;
    total_cnt++;
    if (inv !== 4'b0000) $display("FAIL bp_inv_held: got %b want 0000", inv); else pass_cnt++;
`ifdef SEG7_OVERRUN_FLAG_EN
    total_cnt++;
    if (overrun !== 1'b1) $display("FAIL bp_overrun: got %b want 1", overrun); else pass_cnt++;
`endif
    ready = 1'b1;
    tick();
    total_cnt++;
    if (valid !== 1'b0) $display("FAIL bp_release_drop: got %b want 0", valid); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    ready = 1'b1;
    show(4'b0001, 7'h66, 4);
    show(4'b0010, 7'h6D, 4);
    apply_reset();
    show(4'b0100, 7'h62, 4);
    show(4'b1000, 7'h07, 4);
    show(4'b0000, 7'h00, 2);
    total_cnt++;
    if (valid !== 1'b0) $display("FAIL midreset_partial_discarded: got %b want 0", valid); else pass_cnt++;
    show(4'b0001, 7'h78, 4);
    show(4'b0010, 7'h69, 4);
    dig = '0;
    wait_valid("midreset");
    total_cnt++;
    if (bcd !== 16'h7CDE) $display("FAIL midreset_bcd: got %h want 7cde", bcd); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    ready = 1'b0;
    show(4'b0001, 7'h3F, 4);
    show(4'b0010, 7'h06, 4);
    show(4'b0100, 7'h5B, 4);
    show(4'b1000, 7'h4F, 4);
    dig = '0;
    wait_valid("b2b_first");
    show(4'b0001, 7'h6D, 4);
    show(4'b0010, 7'h7C, 4);
    show(4'b0100, 7'h07, 4);
    show(4'b1000, 7'h7F, 4);
    ready = 1'b1;
    tick();
    total_cnt++;
    if (valid !== 1'b1) $display("FAIL b2b_valid_stays: got %b want 1", valid); else pass_cnt++;
    total_cnt++;
    if (bcd !== 16'h8765) $display("FAIL b2b_reload_bcd: got %h want 8765", bcd); else pass_cnt++;
`ifdef SEG7_OVERRUN_FLAG_EN
    total_cnt++;
    if (overrun !== 1'b0) $display("FAIL b2b_no_overrun: got %b want 0", overrun); else pass_cnt++;
`endif
    dig = '0;
    tick();
    total_cnt++;
    if (valid !== 1'b0) $display("FAIL b2b_valid_drop: got %b want 0", valid); else pass_cnt++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_glitch();
    test_invalid();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
